uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver, 8N1 by default: recovers bytes from an asynchronous serial line using a 16x oversampling enable. It sits directly downstream of the clock divider, which supplies the oversampling rate as a single-cycle `baud_tick` enable in the `clk_in` domain. Received bytes go to the IP's register/AXI side through a valid/ack handshake, with framing and overrun error reporting.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–9), sent LSB first.
- `OVERSAMPLE`, 16, `baud_tick`s per bit period; even, ≥ 8.
- `clk_in` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `baud_tick` input 1: one-cycle enable at OVERSAMPLE × baud; may be tied high.
- `rx_serial` input 1: asynchronous serial line; idles high.
- `data_ack` input 1: consumer accepts `data_out`; clears `data_valid`.
- `data_out` output DATA_BITS: last received byte; reset 0.
- `data_valid` output 1: level, byte pending; reset 0.
- `frame_error` output 1: one-cycle pulse, stop bit sampled 0; reset 0.
- `overrun` output 1: one-cycle pulse, byte overwritten while pending; reset 0.
- `busy` output 1: high in any state but IDLE; reset 0.

## Operation
- `rx_serial` passes through a 2-flop synchronizer that resets to 1. All sampling uses the synchronized value `rx_s`.
- Tick counter `cnt` is `$clog2(OVERSAMPLE)` bits wide and advances only on `baud_tick`. Bit index `idx` is `$clog2(DATA_BITS)` bits wide.
- State machine:
  - **IDLE:** on a tick with `rx_s`=0, go to START with `cnt`=0.
  - **START:** count ticks. On the tick where `cnt`==OVERSAMPLE/2−1:
    - `rx_s`=0: go to DATA, clear `cnt` and `idx`.
    - `rx_s`=1: glitch; return to IDLE with no error.
  - **DATA:** on the tick where `cnt`==OVERSAMPLE−1, shift `rx_s` into the MSB of the shift register (right shift, so the first bit ends in the LSB) and clear `cnt`. After bit DATA_BITS−1, go to PARITY if it is compiled in, otherwise STOP.
  - **STOP:** on the tick where `cnt`==OVERSAMPLE−1, sample the line:
    - `rx_s`=1: load `data_out` and set `data_valid`; go to IDLE.
    - `rx_s`=0: pulse `frame_error`, leave `data_out` unchanged, go to BREAK.
  - **BREAK:** stay until a tick samples `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated starts.
- Handshake:
  - `data_valid` clears on the cycle after `data_ack` is sampled high.
  - `data_ack` while `data_valid`=0 is ignored.
- Overrun: a frame completes while `data_valid`=1 and `data_ack`=0. `data_out` is overwritten, `data_valid` stays 1, and `overrun` pulses.
- Frame completes in the same cycle as `data_ack`: `data_valid` stays 1 with the new byte and there is no overrun.
- `baud_tick` low freezes the state machine and counters. It does not reset them.

## Timing
- Async `rst` mid-frame: state goes to IDLE immediately. All outputs go to their reset values, the synchronizer goes to 1, and `cnt`, `idx` and the shift register go to 0. The partial byte is discarded.
- Input latency: 2 `clk_in` cycles from a `rx_serial` edge to `rx_s`.
- `data_valid`, `frame_error` and `overrun` are registered. They change on the `clk_in` edge following the stop-sample tick.
- With `baud_tick` tied high and OVERSAMPLE=16: `data_valid` rises 2 + 1 + 8 + 16·DATA_BITS + 16 = 155 cycles after the start-bit falling edge on `rx_serial` (DATA_BITS=8).
- Back-to-back frames are supported. A start edge is accepted on the first tick after STOP returns to IDLE.
- There is no combinational path from any input to any output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled at `cnt`==OVERSAMPLE−1.
  - Adds port `parity_error` (output, 1 bit, reset 0). It pulses together with the `data_valid` load when the received bit ≠ even parity (XOR) of the data bits.
  - The byte is still delivered when parity fails.
- Undefined: no PARITY state, no `parity_error` port. Frames are start + DATA_BITS + stop.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `UART_IDLE_LEVEL` = 1'b1;
  - default oversample and data-width constants, shared with the future `uart_tx`.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with parameterized reset value, reused by other async inputs.

## Test plan
All scenarios use OVERSAMPLE=16, DATA_BITS=8 and `baud_tick` tied high unless stated otherwise.
- **Basic receive:** frame 0xA5 → `data_valid` rises 155 cycles after the start edge, `data_out`=0xA5, no error pulses; `data_ack` → `data_valid`=0 the next cycle.
- **Glitch rejection:** `rx_serial` low for 5 cycles, then high → returns to IDLE, `busy` falls, no `data_valid`, no `frame_error`.
- **Framing error and break:** frame 0x3C with stop=0, line then held low 100 cycles, then a valid frame 0x81:
  - one `frame_error` pulse;
  - `data_out` unchanged;
  - no new start during the low period;
  - 0x81 received correctly afterwards.
- **Overrun and simultaneous ack:**
  - frames 0x11 then 0x22 with no ack → `overrun` pulses once, `data_out`=0x22, `data_valid`=1;
  - repeat with `data_ack` landing in the completion cycle → no overrun.
- **Async reset mid-frame:** assert `rst` mid-way through data bit 4 → outputs 0 and `busy`=0 immediately; the next frame 0x5A is received correctly.
- **Throttled tick:** `baud_tick` pulsed every 4th cycle, frame 0xC3 sent at the matching bit rate → `data_out`=0xC3. With `UART_RX_PARITY_EN` defined, a wrong parity bit → `parity_error` pulse and 0xC3 still delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line idle level, default frame geometry.
// No logic; constants only. Also consumed by the future uart_tx.
// No backpressure involved.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL     = 1'b1;
  localparam int   UART_DEF_OVERSAMPLE = 16;
  localparam int   UART_DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, reset value parameterized.
// Latency: 2 clk_in cycles. No backpressure.
// Reused for any async pin; RST_VAL should match the pin's idle level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, optional even parity via UART_RX_PARITY_EN.
// Latency: data_valid 155 clk_in after start edge (8N1, baud_tick tied high).
// Backpressure: none; a byte landing while one is pending overwrites it and pulses overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DEF_DATA_BITS,
  parameter int OVERSAMPLE = UART_DEF_OVERSAMPLE
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  uart_sync2 #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (rx_serial),
    .q      (rx_s)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (data_ack && data_valid) data_valid <= 1'b0;
      // A completing frame below overrides the ack-clear above.
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (rx_s != UART_IDLE_LEVEL) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              if (rx_s != UART_IDLE_LEVEL) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CNT_END) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == CNT_END) begin
              cnt     <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (cnt == CNT_END) begin
              cnt <= '0;
              if (rx_s == UART_IDLE_LEVEL) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                overrun    <= data_valid && !data_ack;
`ifdef UART_RX_PARITY_EN
                parity_error <= (par_bit != ^shreg);
`endif
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_error <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rx_s == UART_IDLE_LEVEL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bytes are queued as expected when a frame is driven and
// popped when the DUT loads data_out. Build with UART_RX_PARITY_EN to cover parity.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int LAT = 155 + 16 * NPAR;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b1;
  logic       rx_serial = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_error, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  logic       par_flip = 1'b0;
  int         pe_cnt = 0;
`endif

  int total = 0, bad = 0;
  int fe_cnt = 0, ov_cnt = 0, load_cnt = 0;
  int tick_div = 1, tick_c = 0;
  int snap;
  logic [7:0] sb_q[$];
  logic       prev_vld = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  always #5 clk_in = ~clk_in;

  uart_rx dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx_serial   (rx_serial),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Tick generator: tied high when tick_div==1, else one pulse every tick_div cycles.
  initial begin
    forever begin
      @(negedge clk_in);
      if (tick_div <= 1) begin
        baud_tick = 1'b1;
      end else begin
        baud_tick = (tick_c == 0);
        tick_c = (tick_c + 1) % tick_div;
      end
    end
  end

  // Monitor: counts pulses and scores every load of data_out.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pe_cnt++;
`endif
      if (data_valid && (!prev_vld || data_out != prev_dat)) begin
        load_cnt++;
        chk("sb_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) chk("rx_byte", 32'(data_out), 32'(sb_q.pop_front()));
      end
      prev_vld = data_valid;
      prev_dat = data_out;
    end
  end

  // Called at a negedge; returns at a negedge with the line left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bitlen);
    if (stop_bit) sb_q.push_back(b);
    rx_serial = 1'b0;
    repeat (bitlen) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (bitlen) @(negedge clk_in);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = (^b) ^ par_flip;
    repeat (bitlen) @(negedge clk_in);
`endif
    rx_serial = stop_bit;
    repeat (bitlen) @(negedge clk_in);
  endtask

  task automatic ack_byte();
    data_ack = 1'b1;
    @(negedge clk_in);
    data_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] pb;
    repeat (3) @(negedge clk_in);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fe", 32'(frame_error), 0);
    chk("rst_ov", 32'(overrun), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);

    // Basic receive with exact latency
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        repeat (LAT - 1) @(negedge clk_in);
        chk("lat_before", 32'(data_valid), 0);
        @(negedge clk_in);
        chk("lat_at", 32'(data_valid), 1);
      end
    join
    chk("basic_data", 32'(data_out), 32'hA5);
    chk("basic_fe", 32'(fe_cnt), 0);
    chk("basic_ov", 32'(ov_cnt), 0);
    ack_byte();
    chk("ack_clear", 32'(data_valid), 0);
    repeat (4) @(negedge clk_in);

    // Glitch rejection
    snap = load_cnt;
    rx_serial = 1'b0;
    repeat (5) @(negedge clk_in);
    rx_serial = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 1);
    repeat (20) @(negedge clk_in);
    chk("glitch_busy_lo", 32'(busy), 0);
    chk("glitch_noload", 32'(load_cnt), 32'(snap));
    chk("glitch_fe", 32'(fe_cnt), 0);

    // Framing error, held-low break, then recovery
    send_frame(8'h3C, 1'b0, 16);
    repeat (100) @(negedge clk_in);
    chk("fe_once", 32'(fe_cnt), 1);
    chk("fe_break_busy", 32'(busy), 1);
    chk("fe_data_kept", 32'(data_out), 32'hA5);
    chk("fe_noload", 32'(load_cnt), 32'(snap));
    rx_serial = 1'b1;
    repeat (20) @(negedge clk_in);
    chk("break_exit", 32'(busy), 0);
    send_frame(8'h81, 1'b1, 16);
    repeat (4) @(negedge clk_in);
    chk("after_break", 32'(data_out), 32'h81);
    chk("after_break_fe", 32'(fe_cnt), 1);
    ack_byte();

    // Overrun: two frames back to back with no ack
    snap = ov_cnt;
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    repeat (4) @(negedge clk_in);
    chk("ovr_pulse", 32'(ov_cnt - snap), 1);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_valid", 32'(data_valid), 1);
    ack_byte();

    // Ack in the completion cycle: no overrun
    send_frame(8'h33, 1'b1, 16);
    snap = ov_cnt;
    fork
      send_frame(8'h44, 1'b1, 16);
      begin
        repeat (LAT - 1) @(negedge clk_in);
        data_ack = 1'b1;
        @(negedge clk_in);
        data_ack = 1'b0;
        chk("simack_valid", 32'(data_valid), 1);
        chk("simack_data", 32'(data_out), 32'h44);
      end
    join
    chk("simack_noov", 32'(ov_cnt - snap), 0);

    // Async reset in the middle of data bit 4, byte 0x44 still pending
    pb = 8'hF0;
    rx_serial = 1'b0;
    repeat (16) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      rx_serial = pb[i];
      repeat (16) @(negedge clk_in);
    end
    rx_serial = pb[4];
    repeat (8) @(negedge clk_in);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(data_valid), 0);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk_in);
    rx_serial = 1'b1;
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    send_frame(8'h5A, 1'b1, 16);
    repeat (4) @(negedge clk_in);
    chk("post_rst_data", 32'(data_out), 32'h5A);
    chk("post_rst_valid", 32'(data_valid), 1);
    ack_byte();

    // Throttled tick: one baud_tick every 4 cycles, 64-cycle bits
    tick_div = 4;
    repeat (8) @(negedge clk_in);
    send_frame(8'hC3, 1'b1, 64);
    repeat (8) @(negedge clk_in);
    chk("thr_data", 32'(data_out), 32'hC3);
    chk("thr_valid", 32'(data_valid), 1);
`ifdef UART_RX_PARITY_EN
    chk("thr_par_ok", 32'(pe_cnt), 0);
`endif
    ack_byte();
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'hC3, 1'b1, 64);
    par_flip = 1'b0;
    repeat (8) @(negedge clk_in);
    chk("par_err", 32'(pe_cnt), 1);
    chk("par_data", 32'(data_out), 32'hC3);
    chk("par_valid", 32'(data_valid), 1);
    ack_byte();
`endif

    tick_div = 1;
    repeat (20) @(negedge clk_in);
    chk("sb_drained", 32'(sb_q.size()), 0);
    chk("final_ov", 32'(ov_cnt), 1);
    chk("final_fe", 32'(fe_cnt), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
